aes_dma_ctrl: RTL and testbench
===============================

AES_DMA_CTRL -- requirements
Module: aes_dma_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 28, block-counter width; block count is size_data[CNT_W+3:4].
REQ-002 SHALL have port hclk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port hreset  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have config inputs: flag in 2 (bit0 start, bit1 abort); data_read_loc in 32 (source byte address); data_write_loc in 32 (destination byte address); size_data in 32 (byte length); key in 128 (cipher key).
REQ-005 SHALL have memory-master ports: mem_req out 1; mem_we out 1; mem_addr out 32; mem_wdata out 32; mem_gnt in 1; mem_rvalid in 1; mem_rdata in 32.
REQ-006 SHALL have cipher-core ports: aes_key out 128; aes_din out 128; aes_start out 1; aes_done in 1; aes_dout in 128.
REQ-007 SHALL have status outputs: busy out 1; done out 1 (one-cycle pulse); err out 1 (one-cycle pulse); blocks_done out CNT_W.

Function
REQ-008 SHALL implement states IDLE, LOAD, CRYPT, STORE, FINISH.
REQ-009 IDLE: on flag[0]=1, SHALL latch data_read_loc, data_write_loc, block count and key into internal registers, clear blocks_done, and enter LOAD; if block count is 0, SHALL enter FINISH instead, with no memory access.
REQ-010 SHALL ignore size_data[3:0], rounding the length down to whole 16-byte blocks.
REQ-011 LOAD: SHALL issue 4 sequential reads at src, src+4, src+8, src+12; word k fills aes_din[127-32k -: 32]; SHALL enter CRYPT on the 4th mem_rvalid.
REQ-012 Handshake: mem_req, mem_we, mem_addr and mem_wdata SHALL stay stable from assertion until the cycle mem_gnt=1, and mem_req SHALL drop the following cycle unless another access starts.
REQ-013 At most one read SHALL be outstanding; the next read request SHALL not be issued before the previous mem_rvalid.
REQ-014 CRYPT: aes_start SHALL pulse high for exactly one cycle on entry, then the block SHALL wait for aes_done and capture aes_dout in that cycle, then enter STORE.
REQ-015 STORE: SHALL issue 4 writes to dst..dst+12 in the same word order; a write completes on mem_gnt.
REQ-016 After the 4th write grant, SHALL increment src and dst by 16 and blocks_done by 1, then enter LOAD if blocks remain, else FINISH.
REQ-017 Address arithmetic SHALL be modulo 2^32; 0xFFFFFFF0+16 SHALL wrap to 0x00000000.
REQ-018 FINISH: SHALL pulse done for one cycle and return to IDLE.
REQ-019 busy SHALL be 1 in every state except IDLE.
REQ-020 flag[0] SHALL be ignored while busy=1.
REQ-021 flag[1]=1 while busy=1 SHALL abort: the block SHALL finish any granted-pending request, then return to IDLE with an err pulse and no done pulse.
REQ-022 flag[1]=1 in IDLE SHALL have no effect.
REQ-023 flag[1] SHALL take priority over flag[0] when both are 1 in the same cycle.
REQ-024 aes_key SHALL output the latched key; it SHALL not change mid-job.

Reset
REQ-025 On hreset=1, SHALL immediately enter IDLE and clear every output to 0, including mem_req, aes_start, done, err, busy, blocks_done, aes_din and aes_key.
REQ-026 Reset mid-job SHALL discard the job; no done or err pulse SHALL be produced.

Configuration
REQ-027 When AES_DMA_IRQ_EN is defined, SHALL add inputs irq_clr in 1 and output irq out 1; irq SHALL set on done or err, clear on irq_clr, and set wins over a same-cycle clear.
REQ-028 When AES_DMA_IRQ_EN is undefined, irq and irq_clr SHALL not exist, and the block SHALL otherwise behave identically.

Structure
REQ-029 A shared package aes_pkg SHALL hold the state enum type, AES_BLK_BYTES=16 and WORDS_PER_BLK=4.
REQ-030 The word sequencer (address/word counter plus req/gnt/rvalid handling) SHALL be a sub-module aes_mem_seq.

Verification
REQ-031 Single block: src=0x100, dst=0x200, size=16, 1-cycle gnt/rvalid -> 4 reads then 1 aes_start then 4 writes to 0x200..0x20C; done pulses once; blocks_done=1.
REQ-032 size_data=0x2F -> exactly 2 blocks processed; last write to dst+0x1C.
REQ-033 size_data=0 -> no mem_req and no aes_start; done pulses within 2 cycles of start.
REQ-034 mem_gnt delayed 5 cycles on each access -> mem_addr is stable during the stall and the output data is unchanged.
REQ-035 Abort asserted during CRYPT of block 2 of 4 -> err pulses, no done, blocks_done=1, busy=0.
REQ-036 hreset pulsed mid-STORE, then src=0xFFFFFFF0 with size=32 -> clean restart; second block reads wrap to 0x0, 0x4, 0x8, 0xC.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES DMA controller and its word sequencer.
package aes_pkg;
  localparam int AES_BLK_BYTES = 16;
  localparam int WORDS_PER_BLK = 4;

  typedef enum logic [2:0] {IDLE, LOAD, CRYPT, STORE, FINISH} state_e;

  // Word k of a block lives at [WORDS_PER_BLK-1-k], i.e. word 0 is bits 127:96.
  typedef logic [WORDS_PER_BLK-1:0][31:0] blk_t;
endpackage

// File: rtl/aes_mem_seq.sv
// Four-word memory sequencer: walks one 16-byte block through the req/gnt/rvalid
// master port, one access at a time, reads never overlapping their rvalid.
module aes_mem_seq import aes_pkg::*; (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        go_i,
  input  logic        we_i,
  input  logic        stop_i,
  input  logic [31:0] rd_base_i,
  input  logic [31:0] wr_base_i,
  input  blk_t        wdata_i,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [1:0]  idx_o,
  output logic        rd_vld_o,
  output logic        acc_done_o,
  output logic        seq_done_o,
  output logic        pend_o
);
  logic       req_q, req_d, we_q, we_d, rvw_q, rvw_d;
  logic [1:0] idx_q, idx_d;

  always_comb begin
    req_d      = req_q;
    we_d       = we_q;
    rvw_d      = rvw_q;
    idx_d      = idx_q;
    rd_vld_o   = rvw_q & mem_rvalid_i;
    acc_done_o = (req_q & mem_gnt_i & we_q) | rd_vld_o;
    seq_done_o = acc_done_o & (idx_q == 2'(WORDS_PER_BLK - 1));
    if (req_q && mem_gnt_i) begin
      req_d = 1'b0;
      if (!we_q) rvw_d = 1'b1;
    end
    if (rd_vld_o) rvw_d = 1'b0;
    // A stop lets the in-flight access finish but launches nothing further.
    if (acc_done_o && !seq_done_o && !stop_i) begin
      idx_d = idx_q + 2'd1;
      req_d = 1'b1;
    end
    if (go_i) begin
      req_d = 1'b1;
      we_d  = we_i;
      idx_d = 2'd0;
      rvw_d = 1'b0;
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      req_q <= 1'b0;
      we_q  <= 1'b0;
      rvw_q <= 1'b0;
      idx_q <= 2'd0;
    end else begin
      req_q <= req_d;
      we_q  <= we_d;
      rvw_q <= rvw_d;
      idx_q <= idx_d;
    end
  end

  assign mem_req_o   = req_q;
  assign mem_we_o    = req_q & we_q;
  assign mem_addr_o  = req_q ? ((we_q ? wr_base_i : rd_base_i) + {28'd0, idx_q, 2'd0}) : 32'd0;
  assign mem_wdata_o = (req_q && we_q) ? wdata_i[~idx_q] : 32'd0;
  assign idx_o       = idx_q;
  assign pend_o      = req_q | rvw_q;
endmodule

// File: rtl/aes_dma_ctrl.sv
// AES DMA controller: streams 16-byte blocks memory -> cipher core -> memory.
// Optional completion interrupt enabled by defining AES_DMA_IRQ_EN.
module aes_dma_ctrl import aes_pkg::*; #(
  parameter int CNT_W = 28
) (
  input  logic             hclk,
  input  logic             hreset,
  input  logic [1:0]       flag,
  input  logic [31:0]      data_read_loc,
  input  logic [31:0]      data_write_loc,
  input  logic [31:0]      size_data,
  input  logic [127:0]     key,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [31:0]      mem_rdata,
  output logic [127:0]     aes_key,
  output logic [127:0]     aes_din,
  output logic             aes_start,
  input  logic             aes_done,
  input  logic [127:0]     aes_dout,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] blocks_done
`ifdef AES_DMA_IRQ_EN
  ,
  input  logic             irq_clr,
  output logic             irq
`endif
);
  state_e           state_q, state_d;
  logic [31:0]      src_q, dst_q;
  logic [CNT_W-1:0] cnt_q, bdone_q, size_blks;
  logic [127:0]     key_q;
  blk_t             din_q, dout_q;
  logic             start_q, err_q, err_d, abort_q;
  logic             launch, ab, aes_acc, last_blk;
  logic             seq_go, seq_we, rd_vld, acc_done, seq_done, pend;
  logic [1:0]       idx;
  logic             unused_lo;

  assign size_blks = size_data[CNT_W+3:4];
  assign unused_lo = ^size_data[3:0];
  assign launch    = (state_q == IDLE) && flag[0] && !flag[1];
  assign ab        = (state_q != IDLE) && (abort_q || flag[1]);
  // The start cycle is skipped so a stale done from the core is never taken.
  assign aes_acc   = (state_q == CRYPT) && aes_done && !start_q;
  assign last_blk  = (bdone_q + CNT_W'(1)) == cnt_q;

  always_comb begin
    state_d = state_q;
    seq_go  = 1'b0;
    seq_we  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (launch) begin
        if (size_blks == '0) state_d = FINISH;
        else begin
          state_d = LOAD;
          seq_go  = 1'b1;
        end
      end
      LOAD: if (ab) begin
        if (!pend || acc_done) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end else if (seq_done) state_d = CRYPT;
      CRYPT: if (ab) begin
        state_d = IDLE;
        err_d   = 1'b1;
      end else if (aes_acc) begin
        state_d = STORE;
        seq_go  = 1'b1;
        seq_we  = 1'b1;
      end
      STORE: if (ab) begin
        if (!pend || acc_done) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end else if (seq_done) begin
        if (last_blk) state_d = FINISH;
        else begin
          state_d = LOAD;
          seq_go  = 1'b1;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      bdone_q <= '0;
      key_q   <= '0;
      din_q   <= '0;
      dout_q  <= '0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      start_q <= (state_d == CRYPT) && (state_q != CRYPT);
      abort_q <= ab && (state_d != IDLE);
      if (launch) begin
        src_q   <= data_read_loc;
        dst_q   <= data_write_loc;
        cnt_q   <= size_blks;
        key_q   <= key;
        bdone_q <= '0;
      end
      if (rd_vld) din_q[~idx] <= mem_rdata;
      if (aes_acc && !ab) dout_q <= aes_dout;
      if ((state_q == STORE) && seq_done && !ab) begin
        src_q   <= src_q + 32'(AES_BLK_BYTES);
        dst_q   <= dst_q + 32'(AES_BLK_BYTES);
        bdone_q <= bdone_q + CNT_W'(1);
      end
    end
  end

  aes_mem_seq u_seq (
    .hclk        (hclk),
    .hreset      (hreset),
    .go_i        (seq_go),
    .we_i        (seq_we),
    .stop_i      (ab),
    .rd_base_i   (src_q),
    .wr_base_i   (dst_q),
    .wdata_i     (dout_q),
    .mem_gnt_i   (mem_gnt),
    .mem_rvalid_i(mem_rvalid),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .idx_o       (idx),
    .rd_vld_o    (rd_vld),
    .acc_done_o  (acc_done),
    .seq_done_o  (seq_done),
    .pend_o      (pend)
  );

  assign aes_key     = key_q;
  assign aes_din     = din_q;
  assign aes_start   = start_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == FINISH);
  assign err         = err_q;
  assign blocks_done = bdone_q;

`ifdef AES_DMA_IRQ_EN
  logic irq_q;
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset)              irq_q <= 1'b0;
    else if (done || err_q)  irq_q <= 1'b1;
    else if (irq_clr)        irq_q <= 1'b0;
  end
  assign irq = irq_q;
`endif
endmodule

// File: tb/tb_aes_dma_ctrl.sv
// Randomized bench for aes_dma_ctrl: reactive memory and cipher-core models plus
// an access-list reference built from the block/address rules.
module tb_aes_dma_ctrl;
  localparam int CNT_W = 28;

  logic             hclk = 1'b0;
  logic             hreset;
  logic [1:0]       flag;
  logic [31:0]      data_read_loc, data_write_loc, size_data;
  logic [127:0]     key;
  logic             mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0]      mem_addr, mem_wdata, mem_rdata;
  logic [127:0]     aes_key, aes_din, aes_dout;
  logic             aes_start, aes_done;
  logic             busy, done, err;
  logic [CNT_W-1:0] blocks_done;
`ifdef AES_DMA_IRQ_EN
  logic             irq_clr, irq;
`endif

  always #5 hclk = ~hclk;

  aes_dma_ctrl #(.CNT_W(CNT_W)) dut (
    .hclk(hclk), .hreset(hreset), .flag(flag),
    .data_read_loc(data_read_loc), .data_write_loc(data_write_loc),
    .size_data(size_data), .key(key),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .aes_key(aes_key), .aes_din(aes_din), .aes_start(aes_start),
    .aes_done(aes_done), .aes_dout(aes_dout),
    .busy(busy), .done(done), .err(err), .blocks_done(blocks_done)
`ifdef AES_DMA_IRQ_EN
    , .irq_clr(irq_clr), .irq(irq)
`endif
  );

  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] data;} acc_t;

  int           tests = 0, fails = 0;
  acc_t         acc_log[$], exp_q[$];
  int           done_cnt, err_cnt, start_cnt, req_cnt, stall_viol, key_viol;
  int           gnt_min = 0, gnt_max = 0;
  logic [31:0]  salt = 32'h1357_9BDF;
  logic [127:0] cur_key;

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  function automatic logic [127:0] cipher(input logic [127:0] d, input logic [127:0] k);
    return {d[95:0], d[127:96]} ^ k ^ 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
  endfunction

  // Expected job trace: per block four reads, then four writes of the enciphered block.
  function automatic void build_exp(input logic [31:0] src, input logic [31:0] dst,
                                    input logic [31:0] size, input logic [127:0] k);
    int nb;
    logic [127:0] blk, outb;
    logic [31:0] a;
    nb = int'(size / 16);
    exp_q.delete();
    for (int b = 0; b < nb; b++) begin
      for (int w = 0; w < 4; w++) begin
        a = src + 32'(16 * b + 4 * w);
        blk[127-32*w -: 32] = rd_word(a);
        exp_q.push_back('{1'b0, a, rd_word(a)});
      end
      outb = cipher(blk, k);
      for (int w = 0; w < 4; w++)
        exp_q.push_back('{1'b1, dst + 32'(16 * b + 4 * w), outb[127-32*w -: 32]});
    end
  endfunction

  function automatic int log_diff();
    if (acc_log.size() != exp_q.size()) return -2;
    foreach (exp_q[i]) if (acc_log[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  // Memory slave: random grant latency, rvalid one cycle after a read grant.
  initial begin : mem_model
    logic [31:0] a0, d0, rvd;
    logic w0;
    int stall, dly;
    bit act, rvp;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    act = 0; rvp = 0; stall = 0; dly = 0; a0 = 0; d0 = 0; w0 = 0; rvd = 0;
    forever begin
      @(posedge hclk); #1;
      mem_gnt = 0; mem_rvalid = 0;
      if (hreset) begin
        act = 0; rvp = 0;
      end else if (rvp) begin
        if (mem_req) stall_viol++;
        mem_rvalid = 1; mem_rdata = rvd; rvp = 0;
      end else if (mem_req) begin
        if (!act) begin
          act = 1; a0 = mem_addr; w0 = mem_we; d0 = mem_wdata; stall = 0;
          dly = int'($urandom_range(gnt_max, gnt_min));
        end else if (mem_addr !== a0 || mem_we !== w0 || (w0 && mem_wdata !== d0))
          stall_viol++;
        if (stall >= dly) begin
          mem_gnt = 1; act = 0;
          acc_log.push_back('{w0, a0, w0 ? d0 : rd_word(a0)});
          if (!w0) begin rvp = 1; rvd = rd_word(a0); end
        end else stall++;
      end else if (act) stall_viol++;
    end
  end

  initial begin : aes_model
    int cd;
    logic [127:0] res;
    aes_done = 0; aes_dout = 0; cd = 0; res = 0;
    forever begin
      @(posedge hclk); #1;
      aes_done = 0;
      if (hreset) cd = 0;
      else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin aes_done = 1; aes_dout = res; end
        end
        if (aes_start) begin
          start_cnt++;
          if (aes_key !== cur_key) key_viol++;
          res = cipher(aes_din, aes_key);
          cd  = int'($urandom_range(4, 2));
        end
      end
    end
  end

  initial forever begin
    @(negedge hclk);
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (mem_req) req_cnt++;
  end

  task automatic clear_counts();
    acc_log.delete();
    done_cnt = 0; err_cnt = 0; start_cnt = 0; req_cnt = 0; stall_viol = 0; key_viol = 0;
  endtask

  task automatic start_job(input logic [31:0] src, input logic [31:0] dst,
                           input logic [31:0] size, input logic [127:0] k);
    cur_key = k;
    @(posedge hclk); #1;
    data_read_loc = src; data_write_loc = dst; size_data = size; key = k; flag = 2'b01;
    @(posedge hclk); #1;
    flag = 2'b00;
    data_read_loc = $urandom; data_write_loc = $urandom; size_data = $urandom;
    key = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_idle(output bit tmo, output int lat);
    tmo = 1; lat = 0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge hclk);
      if (!busy) begin tmo = 0; lat = c; break; end
    end
    repeat (3) @(negedge hclk);
  endtask

  task automatic run_job(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] size,
                         input logic [127:0] k, output bit tmo, output int lat);
    clear_counts();
    build_exp(src, dst, size, k);
    start_job(src, dst, size, k);
    wait_idle(tmo, lat);
  endtask

  task automatic test_reset();
    hreset = 1; flag = 0; data_read_loc = 0; data_write_loc = 0; size_data = 0; key = 0;
`ifdef AES_DMA_IRQ_EN
    irq_clr = 0;
`endif
    repeat (3) @(negedge hclk);
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL reset mem_req got %b want 0", mem_req); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset busy got %b want 0", busy); end
    tests++; if ({done, err, aes_start} !== 3'b000) begin fails++; $display("FAIL reset pulses got %b want 000", {done, err, aes_start}); end
    tests++; if (blocks_done !== '0) begin fails++; $display("FAIL reset blocks_done got %0d want 0", blocks_done); end
    tests++; if (aes_din !== '0 || aes_key !== '0) begin fails++; $display("FAIL reset aes_din/key got %h/%h want 0", aes_din, aes_key); end
    @(posedge hclk); #1; hreset = 0;
    repeat (2) @(negedge hclk);
  endtask

  task automatic test_single();
    bit tmo; int lat, d;
    gnt_min = 0; gnt_max = 0;
    run_job(32'h100, 32'h200, 32'd16, {$urandom, $urandom, $urandom, $urandom}, tmo, lat);
    d = log_diff();
    tests++; if (tmo) begin fails++; $display("FAIL single timeout busy still %b", busy); end
    tests++; if (d !== -1) begin fails++; $display("FAIL single log diff at %0d got %0d entries want %0d", d, acc_log.size(), exp_q.size()); end
    tests++; if (done_cnt !== 1 || err_cnt !== 0) begin fails++; $display("FAIL single done/err got %0d/%0d want 1/0", done_cnt, err_cnt); end
    tests++; if (start_cnt !== 1) begin fails++; $display("FAIL single aes_start count got %0d want 1", start_cnt); end
    tests++; if (blocks_done !== 1) begin fails++; $display("FAIL single blocks_done got %0d want 1", blocks_done); end
    tests++; if (stall_viol + key_viol !== 0) begin fails++; $display("FAIL single protocol got %0d/%0d violations want 0", stall_viol, key_viol); end
  endtask

  task automatic test_partial();
    bit tmo; int lat, d; logic [31:0] src, dst;
    gnt_min = 0; gnt_max = 2;
    src = $urandom & ~32'h3; dst = $urandom & ~32'h3;
    run_job(src, dst, 32'h2F, {$urandom, $urandom, $urandom, $urandom}, tmo, lat);
    d = log_diff();
    tests++; if (tmo || d !== -1) begin fails++; $display("FAIL partial log tmo=%0b diff at %0d got %0d entries want %0d", tmo, d, acc_log.size(), exp_q.size()); end
    tests++; if (blocks_done !== 2) begin fails++; $display("FAIL partial blocks_done got %0d want 2", blocks_done); end
    tests++;
    if (acc_log.size() == 0 || acc_log[acc_log.size()-1].addr !== dst + 32'h1C) begin
      fails++; $display("FAIL partial last write got %0d entries, want last addr %h", acc_log.size(), dst + 32'h1C);
    end
  endtask

  task automatic test_zero();
    bit tmo; int lat;
    logic [31:0] sz [2];
    sz[0] = 32'h0; sz[1] = 32'hF;
    for (int i = 0; i < 2; i++) begin
      run_job($urandom, $urandom, sz[i], {$urandom, $urandom, $urandom, $urandom}, tmo, lat);
      tests++; if (req_cnt !== 0 || start_cnt !== 0) begin fails++; $display("FAIL zero%0d req/start got %0d/%0d want 0/0", i, req_cnt, start_cnt); end
      tests++; if (tmo || lat > 2 || done_cnt !== 1) begin fails++; $display("FAIL zero%0d done got cnt %0d lat %0d want cnt 1 lat<=2", i, done_cnt, lat); end
      tests++; if (blocks_done !== 0) begin fails++; $display("FAIL zero%0d blocks_done got %0d want 0", i, blocks_done); end
    end
  endtask

  task automatic test_stall();
    bit tmo; int lat, d;
    gnt_min = 5; gnt_max = 5;
    run_job($urandom & ~32'h3, $urandom & ~32'h3, 32'd32, {$urandom, $urandom, $urandom, $urandom}, tmo, lat);
    d = log_diff();
    tests++; if (stall_viol !== 0) begin fails++; $display("FAIL stall stability got %0d violations want 0", stall_viol); end
    tests++; if (tmo || d !== -1) begin fails++; $display("FAIL stall log tmo=%0b diff at %0d", tmo, d); end
    tests++; if (done_cnt !== 1 || blocks_done !== 2) begin fails++; $display("FAIL stall done/blocks got %0d/%0d want 1/2", done_cnt, blocks_done); end
  endtask

  task automatic test_random();
    bit tmo; int lat, d; logic [31:0] size;
    for (int i = 0; i < 6; i++) begin
      gnt_min = 0; gnt_max = int'($urandom_range(3, 0));
      salt = $urandom;
      size = $urandom_range(32'h5F, 0);
      run_job($urandom & ~32'h3, $urandom & ~32'h3, size, {$urandom, $urandom, $urandom, $urandom}, tmo, lat);
      d = log_diff();
      tests++; if (tmo || d !== -1) begin fails++; $display("FAIL rand%0d size %h log tmo=%0b diff at %0d", i, size, tmo, d); end
      tests++; if (blocks_done !== CNT_W'(size[31:4]) || done_cnt !== 1) begin fails++; $display("FAIL rand%0d blocks/done got %0d/%0d want %0d/1", i, blocks_done, done_cnt, size[31:4]); end
    end
  endtask

  task automatic test_abort();
    bit tmo; int lat, n;
    gnt_min = 0; gnt_max = 1;
    clear_counts();
    start_job($urandom & ~32'h3, $urandom & ~32'h3, 32'd64, {$urandom, $urandom, $urandom, $urandom});
    n = 0;
    for (int c = 0; c < 2000 && n < 2; c++) begin
      @(posedge hclk); #1;
      if (aes_start) begin
        n++;
        if (n == 2) flag = 2'b10;
      end
    end
    @(posedge hclk); #1; flag = 2'b00;
    wait_idle(tmo, lat);
    tests++; if (tmo || n != 2) begin fails++; $display("FAIL abort reach got starts %0d tmo %0b want 2/0", n, tmo); end
    tests++; if (err_cnt !== 1 || done_cnt !== 0) begin fails++; $display("FAIL abort err/done got %0d/%0d want 1/0", err_cnt, done_cnt); end
    tests++; if (blocks_done !== 1 || busy !== 0) begin fails++; $display("FAIL abort blocks/busy got %0d/%b want 1/0", blocks_done, busy); end
    tests++; if (acc_log.size() !== 12) begin fails++; $display("FAIL abort accesses got %0d want 12", acc_log.size()); end
    // Both flags in idle: abort wins, nothing starts and no err is raised.
    clear_counts();
    @(posedge hclk); #1;
    size_data = 32'd16; flag = 2'b11;
    @(posedge hclk); #1; flag = 2'b00;
    repeat (4) @(negedge hclk);
    tests++; if (busy !== 0 || err_cnt !== 0 || req_cnt !== 0) begin fails++; $display("FAIL idle_flags busy/err/req got %b/%0d/%0d want 0/0/0", busy, err_cnt, req_cnt); end
  endtask

  task automatic test_start_ignored();
    bit tmo; int lat, d;
    gnt_min = 0; gnt_max = 2;
    clear_counts();
    build_exp(32'h4000, 32'h8000, 32'd32, 128'hA5);
    start_job(32'h4000, 32'h8000, 32'd32, 128'hA5);
    repeat (10) @(posedge hclk);
    #1; data_read_loc = 32'h9000; size_data = 32'd64; flag = 2'b01;
    @(posedge hclk); #1; flag = 2'b00;
    wait_idle(tmo, lat);
    d = log_diff();
    tests++; if (tmo || d !== -1 || done_cnt !== 1) begin fails++; $display("FAIL busy_start log diff %0d done %0d want -1/1", d, done_cnt); end
    tests++; if (key_viol !== 0) begin fails++; $display("FAIL busy_start key changed %0d times want 0", key_viol); end
  endtask

  task automatic test_reset_mid();
    bit tmo; int lat, d, hit;
    gnt_min = 0; gnt_max = 1;
    clear_counts();
    start_job(32'h300, 32'h700, 32'd32, {$urandom, $urandom, $urandom, $urandom});
    hit = 0;
    for (int c = 0; c < 2000 && hit == 0; c++) begin
      @(posedge hclk); #1;
      if (mem_req && mem_we) hit = 1;
    end
    #2 hreset = 1;
    #1;
    tests++; if (hit != 1 || busy !== 0 || mem_req !== 0) begin fails++; $display("FAIL mid_reset async hit %0d busy %b req %b want 1/0/0", hit, busy, mem_req); end
    @(posedge hclk); #1; hreset = 0;
    repeat (6) @(negedge hclk);
    tests++; if (done_cnt !== 0 || err_cnt !== 0) begin fails++; $display("FAIL mid_reset pulses done/err got %0d/%0d want 0/0", done_cnt, err_cnt); end
    run_job(32'hFFFF_FFF0, $urandom & ~32'h3, 32'd32, {$urandom, $urandom, $urandom, $urandom}, tmo, lat);
    d = log_diff();
    tests++; if (tmo || d !== -1 || blocks_done !== 2) begin fails++; $display("FAIL wrap log diff %0d blocks %0d want -1/2", d, blocks_done); end
    tests++;
    if (acc_log.size() < 12 || acc_log[8].addr !== 32'h0 || acc_log[9].addr !== 32'h4 ||
        acc_log[10].addr !== 32'h8 || acc_log[11].addr !== 32'hC) begin
      fails++; $display("FAIL wrap second-block reads got %0d entries, want addrs 0/4/8/C", acc_log.size());
    end
  endtask

`ifdef AES_DMA_IRQ_EN
  task automatic test_irq();
    bit tmo; int lat;
    run_job(32'h0, 32'h40, 32'd16, 128'h1, tmo, lat);
    tests++; if (irq !== 1'b1) begin fails++; $display("FAIL irq set got %b want 1", irq); end
    @(posedge hclk); #1; irq_clr = 1;
    @(posedge hclk); #1; irq_clr = 0;
    @(negedge hclk);
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL irq clear got %b want 0", irq); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_partial();
    test_zero();
    test_stall();
    test_random();
    test_abort();
    test_start_ignored();
    test_reset_mid();
`ifdef AES_DMA_IRQ_EN
    test_irq();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired after %0d tests", tests);
    $fatal(1, "watchdog");
  end
endmodule
